// File: rtl/ex_mem_stage_buffer.sv
// EX->MEM pipeline boundary with valid/ready flow control, synchronous flush
// and an optional skid entry. The held entry count doubles as the FSM state
// (EMPTY=0, ONE=1, TWO=2) and is visible on the count output.
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high on that side. Valid must not depend on ready; payload is sampled only
// on an accepting edge. When out_valid is low, every *_MEM output reads 0.
module ex_mem_stage_buffer #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int REG_AW  = 5,
  parameter int ALUOP_W = 8,
  parameter bit SKID    = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               is_write_EX,
  input  logic [REG_AW-1:0]  write_regAddress_EX,
  input  logic [DATA_W-1:0]  write_regValue_EX,
  input  logic [ALUOP_W-1:0] aluop_EX,
  input  logic [ADDR_W-1:0]  mem_address_EX,
  input  logic [DATA_W-1:0]  reg_operation2_value_EX,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               is_write_MEM,
  output logic [REG_AW-1:0]  write_regAddress_MEM,
  output logic [DATA_W-1:0]  write_regValue_MEM,
  output logic [ALUOP_W-1:0] aluop_MEM,
  output logic [ADDR_W-1:0]  mem_address_MEM,
  output logic [DATA_W-1:0]  reg_operation2_value_MEM,
  output logic [1:0]         count
);

  typedef struct packed {
    logic               is_write;
    logic [REG_AW-1:0]  reg_addr;
    logic [DATA_W-1:0]  reg_value;
    logic [ALUOP_W-1:0] aluop;
    logic [ADDR_W-1:0]  mem_addr;
    logic [DATA_W-1:0]  store_data;
  } payload_t;

  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] ONE   = 2'd1;
  localparam logic [1:0] TWO   = 2'd2;

  payload_t   head_q, head_n;
  payload_t   skid_q, skid_n;
  payload_t   in_payload;
  logic [1:0] count_q, count_n;
  logic       rdy_q, rdy_n;
  logic       accept, pop;

  assign in_payload = '{
    is_write:   is_write_EX,
    reg_addr:   write_regAddress_EX,
    reg_value:  write_regValue_EX,
    aluop:      aluop_EX,
    mem_addr:   mem_address_EX,
    store_data: reg_operation2_value_EX
  };

  assign accept = in_valid && in_ready;
  assign pop    = out_valid && out_ready;

  // State register: entry count, head/skid payload and the registered ready.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= EMPTY;
      head_q  <= '0;
      skid_q  <= '0;
      rdy_q   <= 1'b0;
    end else begin
      count_q <= count_n;
      head_q  <= head_n;
      skid_q  <= skid_n;
      rdy_q   <= rdy_n;
    end
  end

  // Next-state logic; vacated entries are zeroed so idle payload stays clean.
  always_comb begin
    count_n = count_q;
    head_n  = head_q;
    skid_n  = skid_q;
    if (flush) begin
      count_n = EMPTY;
      head_n  = '0;
      skid_n  = '0;
    end else begin
      case (count_q)
        EMPTY: begin
          if (accept) begin
            head_n  = in_payload;
            count_n = ONE;
          end
        end
        ONE: begin
          if (accept && pop) begin
            head_n = in_payload;
          end else if (accept) begin
            // Only reachable with the skid entry: head is stalled downstream.
            skid_n  = in_payload;
            count_n = TWO;
          end else if (pop) begin
            head_n  = '0;
            count_n = EMPTY;
          end
        end
        TWO: begin
          if (pop) begin
            head_n  = skid_q;
            skid_n  = '0;
            count_n = ONE;
          end
        end
        default: begin
          count_n = EMPTY;
          head_n  = '0;
          skid_n  = '0;
        end
      endcase
    end
    rdy_n = (count_n != TWO);
  end

  // Output decode: ready selection by build option and valid-gated payload.
  always_comb begin
    out_valid = (count_q != EMPTY);
    count     = count_q;
    if (SKID) begin
      in_ready = rdy_q;
    end else begin
      // Held low while reset is asserted so nothing is offered a false accept.
      in_ready = reset && (!out_valid || out_ready);
    end
    is_write_MEM             = out_valid & head_q.is_write;
    write_regAddress_MEM     = out_valid ? head_q.reg_addr   : '0;
    write_regValue_MEM       = out_valid ? head_q.reg_value  : '0;
    aluop_MEM                = out_valid ? head_q.aluop      : '0;
    mem_address_MEM          = out_valid ? head_q.mem_addr   : '0;
    reg_operation2_value_MEM = out_valid ? head_q.store_data : '0;
  end

endmodule

// File: tb/tb_ex_mem_stage_buffer.sv
// Directed bench for ex_mem_stage_buffer: one SKID=1 instance driven from a
// vector table plus hand-written sequences, and one SKID=0 instance for the
// combinational-ready build.
module tb_ex_mem_stage_buffer;

  typedef struct packed {
    logic        is_write;
    logic [4:0]  reg_addr;
    logic [31:0] reg_value;
    logic [7:0]  aluop;
    logic [31:0] mem_addr;
    logic [31:0] store_data;
  } pay_t;

  typedef struct {
    logic        iv;
    logic        ordy;
    logic        fl;
    logic [31:0] v;
    logic        eov;
    logic [1:0]  ecnt;
    logic        erdy;
    logic [31:0] ev;
  } vec_t;

  // Clock and reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;

  // SKID=1 instance signals
  logic       flush, in_valid, out_ready, in_ready, out_valid;
  logic [1:0] count;
  pay_t       din, dout;

  // SKID=0 instance signals
  logic       flush0, in_valid0, out_ready0, in_ready0, out_valid0;
  logic [1:0] count0;
  pay_t       din0, dout0;

  int n_cmp = 0;
  int n_bad = 0;

  ex_mem_stage_buffer #(.SKID(1'b1)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .is_write_EX(din.is_write), .write_regAddress_EX(din.reg_addr),
    .write_regValue_EX(din.reg_value), .aluop_EX(din.aluop),
    .mem_address_EX(din.mem_addr), .reg_operation2_value_EX(din.store_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .is_write_MEM(dout.is_write), .write_regAddress_MEM(dout.reg_addr),
    .write_regValue_MEM(dout.reg_value), .aluop_MEM(dout.aluop),
    .mem_address_MEM(dout.mem_addr), .reg_operation2_value_MEM(dout.store_data),
    .count(count)
  );

  ex_mem_stage_buffer #(.SKID(1'b0)) dut0 (
    .clk(clk), .reset(reset), .flush(flush0),
    .in_valid(in_valid0), .in_ready(in_ready0),
    .is_write_EX(din0.is_write), .write_regAddress_EX(din0.reg_addr),
    .write_regValue_EX(din0.reg_value), .aluop_EX(din0.aluop),
    .mem_address_EX(din0.mem_addr), .reg_operation2_value_EX(din0.store_data),
    .out_valid(out_valid0), .out_ready(out_ready0),
    .is_write_MEM(dout0.is_write), .write_regAddress_MEM(dout0.reg_addr),
    .write_regValue_MEM(dout0.reg_value), .aluop_MEM(dout0.aluop),
    .mem_address_MEM(dout0.mem_addr), .reg_operation2_value_MEM(dout0.store_data),
    .count(count0)
  );

  // Payload derived from a tag value so every field is distinct per entry.
  function automatic pay_t mk(input logic [31:0] v);
    pay_t p;
    p.is_write   = 1'b1;
    p.reg_addr   = v[4:0];
    p.reg_value  = v;
    p.aluop      = v[7:0] ^ 8'h5A;
    p.mem_addr   = v + 32'h1000;
    p.store_data = ~v;
    return p;
  endfunction

  task automatic cmp(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled on the falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic eov, input logic [1:0] ecnt,
                     input logic erdy, input logic [31:0] ev);
    pay_t ep;
    ep = eov ? mk(ev) : '0;
    cmp({tag, ".out_valid"}, 128'(out_valid), 128'(eov));
    cmp({tag, ".count"},     128'(count),     128'(ecnt));
    cmp({tag, ".in_ready"},  128'(in_ready),  128'(erdy));
    cmp({tag, ".payload"},   128'(dout),      128'(ep));
  endtask

  vec_t tbl[16];
  pay_t exact;

  initial begin
    // Vector table: inputs for one edge, expected state after that edge.
    //            iv ordy fl  v      eov cnt  rdy  ev
    tbl[0]  = '{1, 0, 0, 32'h1, 1, 2'd1, 1, 32'h1};  // accept A
    tbl[1]  = '{1, 0, 0, 32'h2, 1, 2'd2, 0, 32'h1};  // accept B into skid
    tbl[2]  = '{1, 0, 0, 32'h3, 1, 2'd2, 0, 32'h1};  // C held off
    tbl[3]  = '{1, 1, 0, 32'h3, 1, 2'd1, 1, 32'h2};  // pop A, B to head
    tbl[4]  = '{1, 1, 0, 32'h3, 1, 2'd1, 1, 32'h3};  // accept C + pop B
    tbl[5]  = '{0, 1, 0, 32'h9, 0, 2'd0, 1, 32'h0};  // pop C, idle input ignored
    tbl[6]  = '{1, 0, 0, 32'h4, 1, 2'd1, 1, 32'h4};
    tbl[7]  = '{1, 0, 0, 32'h5, 1, 2'd2, 0, 32'h4};
    tbl[8]  = '{1, 0, 1, 32'h6, 0, 2'd0, 1, 32'h0};  // flush at count 2
    tbl[9]  = '{1, 0, 0, 32'h7, 1, 2'd1, 1, 32'h7};
    tbl[10] = '{1, 1, 1, 32'h8, 0, 2'd0, 1, 32'h0};  // flush beats accept+pop
    tbl[11] = '{0, 1, 0, 32'h8, 0, 2'd0, 1, 32'h0};  // 8 never shows up
    tbl[12] = '{1, 1, 0, 32'hA, 1, 2'd1, 1, 32'hA};
    tbl[13] = '{1, 1, 0, 32'hB, 1, 2'd1, 1, 32'hB};
    tbl[14] = '{0, 0, 0, 32'hC, 1, 2'd1, 1, 32'hB};  // stalled, hold
    tbl[15] = '{0, 1, 0, 32'hC, 0, 2'd0, 1, 32'h0};

    reset = 1'b0;
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; din = '0;
    flush0 = 1'b0; in_valid0 = 1'b0; out_ready0 = 1'b0; din0 = '0;

    // Reset state
    step();
    step();
    chk("reset", 1'b0, 2'd0, 1'b0, 32'h0);
    cmp("reset.in_ready0", 128'(in_ready0), 128'(1'b0));
    cmp("reset.out_valid0", 128'(out_valid0), 128'(1'b0));
    reset = 1'b1;
    step();
    chk("post_reset", 1'b0, 2'd0, 1'b1, 32'h0);

    // Table-driven vectors
    for (int i = 0; i < 16; i++) begin
      in_valid  = tbl[i].iv;
      out_ready = tbl[i].ordy;
      flush     = tbl[i].fl;
      din       = mk(tbl[i].v);
      step();
      chk($sformatf("vec%0d", i), tbl[i].eov, tbl[i].ecnt, tbl[i].erdy, tbl[i].ev);
    end
    flush = 1'b0;

    // Pass-through with the exact payload
    exact = '{1'b1, 5'd3, 32'hDEAD_BEEF, 8'h21, 32'h0000_4000, 32'h1234_5678};
    din = exact; in_valid = 1'b1; out_ready = 1'b1;
    step();
    cmp("pass.payload", 128'(dout), 128'(exact));
    cmp("pass.out_valid", 128'(out_valid), 128'(1'b1));
    cmp("pass.count", 128'(count), 128'(2'd1));
    in_valid = 1'b0;
    step();
    chk("pass.drain", 1'b0, 2'd0, 1'b1, 32'h0);

    // Back-to-back stream: each entry one cycle later, no bubbles
    in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      din = mk(32'd100 + 32'(i));
      step();
      chk($sformatf("stream%0d", i), 1'b1, 2'd1, 1'b1, 32'd100 + 32'(i));
    end
    in_valid = 1'b0;
    step();
    chk("stream.drain", 1'b0, 2'd0, 1'b1, 32'h0);

    // Asynchronous reset with two entries held
    in_valid = 1'b1; out_ready = 1'b0; din = mk(32'h51);
    step();
    din = mk(32'h52);
    step();
    chk("pre_areset", 1'b1, 2'd2, 1'b0, 32'h51);
    in_valid = 1'b0;
    #2 reset = 1'b0;
    #1 chk("areset", 1'b0, 2'd0, 1'b0, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    step();
    chk("areset.release", 1'b0, 2'd0, 1'b1, 32'h0);

    // SKID=0 build: combinational ready and no-bubble swap
    in_valid0 = 1'b1; out_ready0 = 1'b0; din0 = mk(32'h11);
    #1 cmp("s0.rdy_empty", 128'(in_ready0), 128'(1'b1));
    step();
    cmp("s0.head", 128'(dout0), 128'(mk(32'h11)));
    cmp("s0.count", 128'(count0), 128'(2'd1));
    cmp("s0.rdy_stalled", 128'(in_ready0), 128'(1'b0));
    out_ready0 = 1'b1; din0 = mk(32'h22);
    #1 cmp("s0.rdy_comb", 128'(in_ready0), 128'(1'b1));
    step();
    cmp("s0.swap", 128'(dout0), 128'(mk(32'h22)));
    cmp("s0.swap_valid", 128'(out_valid0), 128'(1'b1));
    in_valid0 = 1'b0;
    step();
    cmp("s0.drain_valid", 128'(out_valid0), 128'(1'b0));
    cmp("s0.drain_payload", 128'(dout0), 128'(0));
    cmp("s0.drain_count", 128'(count0), 128'(2'd0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ex_mem_stage_buffer.md
Name: ex_mem_stage_buffer

Overview:
- Parametrised EX→MEM pipeline boundary that replaces the plain clocked EX/MEM register.
- Adds valid/ready flow control, synchronous flush, and an optional second (skid) entry, so the EX stage can be back-pressured by a multi-cycle memory stage without losing an instruction.
- Carries the same fields as today: write-back control, ALU op, memory address, store data.
- Unlike the current register, every payload field has a defined reset value.

Parameters:
- DATA_W, 32, width of write_regValue and reg_operation2_value.
- ADDR_W, 32, width of mem_address.
- REG_AW, 5, width of write_regAddress.
- ALUOP_W, 8, width of aluop.
- SKID, 1, 1 = two entries with registered in_ready; 0 = single entry with combinational in_ready.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- reset  in  1  asynchronous active-low reset (0 = reset asserted).
- flush  in  1  synchronous discard of all held entries.
- in_valid  in  1  EX presents a valid instruction.
- in_ready  out  1  buffer accepts this cycle.
- is_write_EX  in  1  destination register write enable.
- write_regAddress_EX  in  REG_AW  destination register address.
- write_regValue_EX  in  DATA_W  destination register value.
- aluop_EX  in  ALUOP_W  ALU op code.
- mem_address_EX  in  ADDR_W  load/store address.
- reg_operation2_value_EX  in  DATA_W  store data.
- out_valid  out  1  MEM-side entry valid.
- out_ready  in  1  MEM consumes this cycle.
- is_write_MEM, write_regAddress_MEM, write_regValue_MEM, aluop_MEM, mem_address_MEM, reg_operation2_value_MEM  out  (widths as EX counterparts)  head-entry payload.
- count  out  2  entries held (0..2; 0..1 when SKID=0).

Behaviour:
- Accept: in_valid && in_ready. Pop: out_valid && out_ready.
- Latency: an accepted instruction appears on the outputs the next cycle when the buffer was empty or popped in the same cycle.
- Reset (reset=0, asynchronous):
  - out_valid=0, count=0, all *_MEM payload=0.
  - in_ready=0 while reset is asserted; in_ready=1 in the first cycle after release.
- Payload gating: when out_valid=0, all *_MEM outputs are 0. In particular, is_write_MEM is never 1 without out_valid.
- SKID=1 states (count):
  - EMPTY(0): in_ready=1. Accept → ONE.
  - ONE(1): in_ready=1.
    - Accept and pop → ONE, head replaced by the new entry.
    - Accept only → TWO; the new entry goes to skid.
    - Pop only → EMPTY.
  - TWO(2): in_ready=0.
    - Pop → ONE; skid moves to head.
    - No pop → hold.
- SKID=1 timing: in_ready is a registered output, equal to (next count != 2). There is no combinational path from out_ready to in_ready.
- SKID=0:
  - Single head entry; in_ready = !out_valid || out_ready (combinational).
  - Accept with simultaneous pop replaces the head.
- Order: strict FIFO; no reordering, no duplication, no drop except by flush.
- Flush:
  - Next edge: count=0, out_valid=0, payload=0.
  - Flush overrides a same-cycle accept (the incoming instruction is discarded) and a same-cycle pop (the pop still counts as consumed by MEM).
  - in_ready=1 the cycle after flush.
- Reset mid-operation: asynchronous clear to the reset values regardless of state; held entries are lost.
- Payload is captured only on accept. Inputs while in_valid=0 or in_ready=0 are ignored.

Test Plan:
- Reset/idle: assert reset=0 mid-stream with count=2 → out_valid=0, count=0, all *_MEM=0 immediately. After release, in_ready=1.
- Pass-through: out_ready=1; accept is_write=1, addr=5'd3, value=32'hDEAD_BEEF, aluop=8'h21 → next cycle out_valid=1 with identical payload, count=1. Stream of 10 back-to-back instructions → each emerges one cycle later, no bubbles.
- Back-pressure (SKID=1): out_ready=0; accept A=32'h1, B=32'h2 → count=2, in_ready=0, C is held off. Raise out_ready → A, B, C emerge in order; in_ready returns to 1 one cycle after the first pop.
- Simultaneous accept+pop at count=1 → count stays 1, head becomes the new entry.
- Flush: count=2 with flush=1, in_valid=1 on the same cycle → next cycle count=0, out_valid=0, is_write_MEM=0; the incoming instruction never appears.
- SKID=0 build: out_ready=0 with head valid → in_ready=0. Toggle out_ready=1 → in_ready=1 in the same cycle (combinational). Accept+pop → payload swaps with no bubble.
